// File: rtl/sdram_row_buffer_ctrl_if.sv
// Command/data bus between the SDRAM command decoder and the row buffer.
// master: decoder side (drives commands and write beats); slave: controller.
interface sdram_row_buffer_ctrl_if #(
  parameter int DATA_SIZE     = 32,
  parameter int COL_ADDR_SIZE = 8,
  parameter int ROW_ADDR_SIZE = 12
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [2:0]               cmd_op;
  logic [ROW_ADDR_SIZE-1:0] cmd_row;
  logic [COL_ADDR_SIZE-1:0] cmd_col;
  logic [DATA_SIZE-1:0]     wr_data;
  logic [DATA_SIZE/8-1:0]   wr_mask;
  logic [DATA_SIZE-1:0]     rd_data;
  logic                     rd_valid;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col,
    output wr_data, wr_mask,
    input  cmd_ready, rd_data, rd_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col,
    input  wr_data, wr_mask,
    output cmd_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/sdram_row_buffer_ctrl.sv
// Single-bank open-row buffer: ACT/RD/WR/PRE with wrapped bursts.
// Ports: clk, rst_n, bus (command/data), arr_* (bank array), status.
module sdram_row_buffer_ctrl #(
  parameter int ROW_BUFFER_SIZE = 2048,
  parameter int DATA_SIZE       = 32,
  parameter int COL_ADDR_SIZE   = 8,
  parameter int ROW_ADDR_SIZE   = 12,
  parameter int BURST_LEN       = 4,
  parameter int CAS_LATENCY     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sdram_row_buffer_ctrl_if.slave     bus,
  output logic [ROW_ADDR_SIZE-1:0]   arr_row,
  output logic                       arr_rd_req,
  input  logic                       arr_rd_ack,
  input  logic [ROW_BUFFER_SIZE-1:0] arr_rd_data,
  output logic                       arr_wr_req,
  input  logic                       arr_wr_ack,
  output logic [ROW_BUFFER_SIZE-1:0] arr_wr_data,
  output logic                       row_open,
  output logic [ROW_ADDR_SIZE-1:0]   open_row,
  output logic                       err
);

  localparam int WORDS  = ROW_BUFFER_SIZE / DATA_SIZE;
  localparam int WORD_W = $clog2(WORDS);
  localparam int BYTES  = DATA_SIZE / 8;
  localparam int BYTE_W = $clog2(BYTES);
  localparam logic [WORD_W-1:0] BMASK =
    WORD_W'(BURST_LEN - 1);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;

  typedef enum logic [2:0] {
    IDLE, LOAD, ACTIVE, WBURST, RBURST, STORE
  } state_t;

  state_t                     state;
  logic [ROW_BUFFER_SIZE-1:0] rowBuf;
  logic                       dirty;
  logic [WORD_W-1:0]          baseWord;
  logic [WORD_W-1:0]          beatCnt;
  logic [DATA_SIZE-1:0]       pipeD [CAS_LATENCY];
  logic [CAS_LATENCY-1:0]     pipeV;

  logic                 cmdFire;
  logic [WORD_W-1:0]    colWord;
  logic                 wrEn;
  logic [WORD_W-1:0]    wrWord;
  logic                 capV;
  logic [WORD_W-1:0]    capWord;
  logic [DATA_SIZE-1:0] capData;
  logic                 lastBeat;

  // Sequential wrap inside the burst-aligned block of words.
  function automatic logic [WORD_W-1:0] wordAt(
    input logic [WORD_W-1:0] base,
    input logic [WORD_W-1:0] k
  );
    return (base & ~BMASK) | ((base + k) & BMASK);
  endfunction

  assign cmdFire  = bus.cmd_valid && bus.cmd_ready;
  assign colWord  = WORD_W'(bus.cmd_col >> BYTE_W);
  assign lastBeat = (beatCnt == BMASK);

  assign arr_wr_data = rowBuf;
  assign bus.rd_data  = pipeD[CAS_LATENCY-1];
  assign bus.rd_valid = pipeV[CAS_LATENCY-1];

  always_comb begin
    wrEn    = 1'b0;
    wrWord  = '0;
    capV    = 1'b0;
    capWord = '0;
    if (state == ACTIVE && cmdFire) begin
      if (bus.cmd_op == OP_WR) begin
        wrEn   = 1'b1;
        wrWord = wordAt(colWord, '0);
      end
      if (bus.cmd_op == OP_RD) begin
        capV    = 1'b1;
        capWord = wordAt(colWord, '0);
      end
    end
    if (state == WBURST) begin
      wrEn   = 1'b1;
      wrWord = wordAt(baseWord, beatCnt);
    end
    if (state == RBURST) begin
      capV    = 1'b1;
      capWord = wordAt(baseWord, beatCnt);
    end
  end

  assign capData =
    rowBuf[int'(capWord)*DATA_SIZE +: DATA_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rowBuf        <= '0;
      dirty         <= 1'b0;
      baseWord      <= '0;
      beatCnt       <= '0;
      pipeV         <= '0;
      for (int i = 0; i < CAS_LATENCY; i++)
        pipeD[i] <= '0;
      bus.cmd_ready <= 1'b1;
      arr_rd_req    <= 1'b0;
      arr_wr_req    <= 1'b0;
      arr_row       <= '0;
      row_open      <= 1'b0;
      open_row      <= '0;
      err           <= 1'b0;
    end else begin
      err <= 1'b0;

      // Read pipeline drains independently of the FSM.
      pipeV[0] <= capV;
      if (capV)
        pipeD[0] <= capData;
      for (int i = 1; i < CAS_LATENCY; i++) begin
        pipeV[i] <= pipeV[i-1];
        if (pipeV[i-1])
          pipeD[i] <= pipeD[i-1];
      end

      if (wrEn) begin
        for (int b = 0; b < BYTES; b++)
          if (bus.wr_mask[b])
            rowBuf[int'(wrWord)*DATA_SIZE + b*8 +: 8]
              <= bus.wr_data[b*8 +: 8];
        if (|bus.wr_mask)
          dirty <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (cmdFire) begin
            case (bus.cmd_op)
              OP_NOP: ;
              OP_ACT: begin
                arr_row       <= bus.cmd_row;
                open_row      <= bus.cmd_row;
                arr_rd_req    <= 1'b1;
                bus.cmd_ready <= 1'b0;
                state         <= LOAD;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        LOAD: begin
          if (arr_rd_ack) begin
            rowBuf        <= arr_rd_data;
            dirty         <= 1'b0;
            row_open      <= 1'b1;
            arr_rd_req    <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cmdFire) begin
            case (bus.cmd_op)
              OP_NOP: ;
              OP_WR, OP_RD: begin
                baseWord <= colWord;
                beatCnt  <= WORD_W'(1);
                if (BURST_LEN > 1) begin
                  bus.cmd_ready <= 1'b0;
                  state <= (bus.cmd_op == OP_WR)
                           ? WBURST : RBURST;
                end
              end
              OP_PRE: begin
                if (dirty) begin
                  arr_row       <= open_row;
                  arr_wr_req    <= 1'b1;
                  bus.cmd_ready <= 1'b0;
                  state         <= STORE;
                end else begin
                  row_open <= 1'b0;
                  state    <= IDLE;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        WBURST, RBURST: begin
          beatCnt <= beatCnt + WORD_W'(1);
          if (lastBeat) begin
            bus.cmd_ready <= 1'b1;
            state         <= ACTIVE;
          end
        end
        STORE: begin
          if (arr_wr_ack) begin
            dirty         <= 1'b0;
            row_open      <= 1'b0;
            arr_wr_req    <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_row_buffer_ctrl.sv
// Scoreboard bench for sdram_row_buffer_ctrl: directed commands,
// array responder, read monitor and write-back monitor.
module tb_sdram_row_buffer_ctrl;

  localparam int RBS = 2048;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int RW  = 12;
  localparam int BL  = 4;
  localparam int CL  = 2;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] ACT = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] WR  = 3'd3;
  localparam logic [2:0] PRE = 3'd4;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } rdExp_t;

  typedef struct {
    logic [RBS-1:0] img;
    logic [RW-1:0]  row;
  } wrExp_t;

  logic           clk;
  logic           rst_n;
  logic [RW-1:0]  arr_row;
  logic           arr_rd_req;
  logic           arr_rd_ack;
  logic [RBS-1:0] arr_rd_data;
  logic           arr_wr_req;
  logic           arr_wr_ack;
  logic [RBS-1:0] arr_wr_data;
  logic           row_open;
  logic [RW-1:0]  open_row;
  logic           err;

  sdram_row_buffer_ctrl_if #(
    .DATA_SIZE(DW), .COL_ADDR_SIZE(CW), .ROW_ADDR_SIZE(RW)
  ) bus ();

  sdram_row_buffer_ctrl #(
    .ROW_BUFFER_SIZE(RBS), .DATA_SIZE(DW),
    .COL_ADDR_SIZE(CW), .ROW_ADDR_SIZE(RW),
    .BURST_LEN(BL), .CAS_LATENCY(CL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .arr_row(arr_row),
    .arr_rd_req(arr_rd_req),
    .arr_rd_ack(arr_rd_ack),
    .arr_rd_data(arr_rd_data),
    .arr_wr_req(arr_wr_req),
    .arr_wr_ack(arr_wr_ack),
    .arr_wr_data(arr_wr_data),
    .row_open(row_open),
    .open_row(open_row),
    .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdDelay = 3;
  int wrDelay = 2;
  int rdCnt = 0;
  int wrCnt = 0;
  int lastRdLen = 0;
  int ackCyc = 0;
  int readyCyc = 0;
  int wrReqSeen = 0;
  int acceptCyc = 0;
  logic [RBS-1:0] model;
  rdExp_t rdQ [$];
  wrExp_t wrQ [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Array model: ack after rdDelay/wrDelay request cycles.
  initial begin
    arr_rd_ack = 1'b0;
    arr_wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (arr_rd_req) begin
        rdCnt++;
        arr_rd_ack = (rdCnt == rdDelay);
        if (arr_rd_ack)
          ackCyc = cyc;
      end else begin
        if (rdCnt != 0)
          lastRdLen = rdCnt;
        rdCnt = 0;
        arr_rd_ack = 1'b0;
      end
      if (arr_wr_req) begin
        wrCnt++;
        if (wrCnt == 1) begin
          wrReqSeen++;
          if (wrQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected actual=req required=none");
          end else begin
            wrExp_t e;
            e = wrQ.pop_front();
            chk("wr_row", 64'(arr_row), 64'(e.row));
            checks++;
            if (arr_wr_data !== e.img) begin
              errors++;
              for (int j = 0; j < RBS/DW; j++)
                if (arr_wr_data[j*DW +: DW] !== e.img[j*DW +: DW]) begin
                  $display("FAIL wr_data word %0d actual=%h required=%h",
                           j, arr_wr_data[j*DW +: DW],
                           e.img[j*DW +: DW]);
                  break;
                end
            end
          end
        end
        arr_wr_ack = (wrCnt == wrDelay);
      end else begin
        wrCnt = 0;
        arr_wr_ack = 1'b0;
      end
    end
  end

  // Read monitor.
  initial forever begin
    @(negedge clk);
    if (bus.rd_valid) begin
      if (rdQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%h required=none",
                 bus.rd_data);
      end else begin
        rdExp_t e;
        e = rdQ.pop_front();
        chk("rd_data", 64'(bus.rd_data), 64'(e.d));
        chk("rd_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic sendCmd(input logic [2:0] op,
                         input logic [RW-1:0] row,
                         input logic [CW-1:0] col,
                         input logic [DW-1:0] d,
                         input logic [3:0] m);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_row   = row;
    bus.cmd_col   = col;
    bus.wr_data   = d;
    bus.wr_mask   = m;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept actual=timeout required=ready");
    end
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.wr_mask   = '0;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_ready actual=timeout required=ready");
    end
    readyCyc = cyc;
  endtask

  task automatic modelWrite(input int w,
                            input logic [DW-1:0] d,
                            input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (m[b])
        model[w*DW + b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic writeBurst(input logic [CW-1:0] col,
                            input logic [DW-1:0] d0, d1, d2, d3,
                            input logic [3:0] m0, m1, m2, m3);
    int w;
    w = int'(col) >> 2;
    modelWrite(w, d0, m0);
    modelWrite((w & ~3) | ((w + 1) & 3), d1, m1);
    modelWrite((w & ~3) | ((w + 2) & 3), d2, m2);
    modelWrite((w & ~3) | ((w + 3) & 3), d3, m3);
    sendCmd(WR, '0, col, d0, m0);
    bus.wr_data = d1;
    bus.wr_mask = m1;
    @(posedge clk);
    #1;
    bus.wr_data = d2;
    bus.wr_mask = m2;
    @(posedge clk);
    #1;
    bus.wr_data = d3;
    bus.wr_mask = m3;
    @(posedge clk);
    #1;
    bus.wr_mask = '0;
  endtask

  task automatic expectRd(input int acc,
                          input logic [DW-1:0] w0, w1, w2, w3);
    rdExp_t e;
    e.d = w0; e.c = acc + CL - 1;     rdQ.push_back(e);
    e.d = w1; e.c = acc + CL;         rdQ.push_back(e);
    e.d = w2; e.c = acc + CL + 1;     rdQ.push_back(e);
    e.d = w3; e.c = acc + CL + 2;     rdQ.push_back(e);
  endtask

  task automatic pushWr(input logic [RW-1:0] row);
    wrExp_t e;
    e.img = model;
    e.row = row;
    wrQ.push_back(e);
  endtask

  initial begin
    for (int j = 0; j < RBS/DW; j++)
      arr_rd_data[j*DW +: DW] = 32'h1000_0000 + 32'(j);
    arr_rd_data[3*DW +: DW] = 32'hDEAD_BEEF;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.cmd_row   = '0;
    bus.cmd_col   = '0;
    bus.wr_data   = '0;
    bus.wr_mask   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_arr_rd_req", 64'(arr_rd_req), 64'd0);
    chk("rst_arr_wr_req", 64'(arr_wr_req), 64'd0);
    chk("rst_arr_row", 64'(arr_row), 64'd0);
    chk("rst_row_open", 64'(row_open), 64'd0);
    chk("rst_open_row", 64'(open_row), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ACT with a 3-cycle array load.
    rdDelay = 3;
    model = arr_rd_data;
    sendCmd(ACT, 12'h005, '0, '0, '0);
    chk("act_rd_req", 64'(arr_rd_req), 64'd1);
    chk("act_arr_row", 64'(arr_row), 64'h005);
    waitReady();
    @(negedge clk);
    chk("act_req_len", 64'(lastRdLen), 64'd3);
    chk("act_ready_cyc", 64'(readyCyc), 64'(ackCyc + 1));
    chk("act_row_open", 64'(row_open), 64'd1);
    chk("act_open_row", 64'(open_row), 64'h005);

    // RD word 3 wraps 3,0,1,2.
    sendCmd(RD, '0, 8'h0C, '0, '0);
    expectRd(acceptCyc, 32'hDEAD_BEEF, 32'h1000_0000,
             32'h1000_0001, 32'h1000_0002);

    // WR word 2 with masks F,1,F,0 while the RD drains.
    writeBurst(8'h08, 32'h1111_1111, 32'h2222_2222,
               32'h3333_3333, 32'h4444_4444,
               4'hF, 4'h1, 4'hF, 4'h0);

    // Back-to-back RDs of the updated block.
    sendCmd(RD, '0, 8'h00, '0, '0);
    expectRd(acceptCyc, 32'h3333_3333, 32'h1000_0001,
             32'h1111_1111, 32'hDEAD_BE22);
    sendCmd(RD, '0, 8'h0C, '0, '0);
    expectRd(acceptCyc, 32'hDEAD_BE22, 32'h3333_3333,
             32'h1000_0001, 32'h1111_1111);
    repeat (8) @(negedge clk);
    chk("rd_hold_valid", 64'(bus.rd_valid), 64'd0);
    chk("rd_hold_data", 64'(bus.rd_data), 64'h1111_1111);

    // Dirty PRE writes back.
    wrDelay = 2;
    pushWr(12'h005);
    sendCmd(PRE, '0, '0, '0, '0);
    chk("pre_wr_req", 64'(arr_wr_req), 64'd1);
    waitReady();
    @(negedge clk);
    chk("pre_row_open", 64'(row_open), 64'd0);
    chk("pre_wr_seen", 64'(wrReqSeen), 64'd1);
    chk("pre_wr_req_low", 64'(arr_wr_req), 64'd0);

    // Clean PRE: no array write.
    rdDelay = 1;
    sendCmd(ACT, 12'h0A3, '0, '0, '0);
    waitReady();
    sendCmd(PRE, '0, '0, '0, '0);
    chk("clean_pre_row_open", 64'(row_open), 64'd0);
    chk("clean_pre_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("clean_pre_no_wr", 64'(wrReqSeen), 64'd1);

    // Illegal commands.
    sendCmd(RD, '0, '0, '0, '0);
    chk("ill_rd_err", 64'(err), 64'd1);
    chk("ill_rd_row_open", 64'(row_open), 64'd0);
    chk("ill_rd_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("ill_rd_err_end", 64'(err), 64'd0);
    sendCmd(ACT, 12'h0B7, '0, '0, '0);
    waitReady();
    sendCmd(ACT, 12'h0C8, '0, '0, '0);
    chk("ill_act_err", 64'(err), 64'd1);
    chk("ill_act_open_row", 64'(open_row), 64'h0B7);
    chk("ill_act_row_open", 64'(row_open), 64'd1);
    chk("ill_act_rd_req", 64'(arr_rd_req), 64'd0);
    @(posedge clk);
    #1;
    chk("ill_act_err_end", 64'(err), 64'd0);
    sendCmd(3'd6, '0, '0, '0, '0);
    chk("ill_op6_err", 64'(err), 64'd1);
    chk("ill_op6_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("ill_op6_err_end", 64'(err), 64'd0);

    // Reset during STORE before ack.
    model = arr_rd_data;
    writeBurst(8'h00, 32'hA0A0_A0A0, 32'hB0B0_B0B0,
               32'hC0C0_C0C0, 32'hD0D0_D0D0,
               4'hF, 4'hF, 4'hF, 4'hF);
    wrDelay = 1000;
    pushWr(12'h0B7);
    sendCmd(PRE, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("store_wr_req", 64'(arr_wr_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_store_wr_req", 64'(arr_wr_req), 64'd0);
    chk("rst_store_row_open", 64'(row_open), 64'd0);
    chk("rst_store_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_store_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wrDelay = 2;
    @(negedge clk);

    // Normal operation after reset.
    rdDelay = 2;
    sendCmd(ACT, 12'h123, '0, '0, '0);
    waitReady();
    chk("post_row_open", 64'(row_open), 64'd1);
    chk("post_open_row", 64'(open_row), 64'h123);
    sendCmd(RD, '0, 8'h04, '0, '0);
    expectRd(acceptCyc, 32'h1000_0001, 32'h1000_0002,
             32'hDEAD_BEEF, 32'h1000_0000);
    repeat (8) @(negedge clk);
    chk("rd_queue_empty", 64'(rdQ.size()), 64'd0);
    chk("wr_queue_empty", 64'(wrQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
